div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative unsigned long divider among NREQ requesters. It accepts one request at a time over per-requester valid/ready, issues the divider start pulse, and waits for completion. It then returns quotient, remainder, divide-by-zero flag and requester ID on a single valid/ready response port. It sits between DSP channels needing occasional division (normalisation, scaling) and the single divider instance.

---
 rtl/div_arb_pkg.sv | 48 ++++
 rtl/div_arbiter_if.sv | 40 ++++
 rtl/div_arbiter_long_division.sv | 82 ++++++++
 rtl/div_arbiter.sv | 115 +++++++++++
 tb/tb_div_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding,
// requester-ID width rule and the round-robin winner search.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Widest requester set the winner search supports.
  localparam int MAX_NREQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // ID width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First valid index scanning ptr, ptr+1, ... wrapping at n. Offsets are
  // walked from the far end so the nearest valid requester is written last.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                    input logic [3:0] ptr,
                                    input int n);
    pick_t      r;
    int         idx;
    logic [3:0] idx4;
    r = '0;
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        idx4 = idx[3:0];
        if (valid[idx4]) begin
          r.found = 1'b1;
          r.idx   = idx4;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Bus bundle between the requesters/response consumer and div_arbiter.
//
// Handshake rule for both the request and the response side: a transfer
// happens on a rising i_clk edge where valid and ready are both high. The
// source holds valid and its payload steady until that edge; ready may
// change freely and carries no meaning while valid is low.
interface div_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  import div_arb_pkg::*;

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ*WIDTH-1:0] i_req_a;
  logic [NREQ*WIDTH-1:0] i_req_b;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [IDW-1:0]        o_rsp_id;
  logic [WIDTH-1:0]      o_rsp_quot;
  logic [WIDTH-1:0]      o_rsp_rem;
  logic                  o_rsp_dbz;
  logic                  o_busy;
  state_t                o_state;  // arbiter FSM state, for observation

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_quot, o_rsp_rem,
           o_rsp_dbz, o_busy, o_state
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_quot, o_rsp_rem,
           o_rsp_dbz, o_busy, o_state
  );

endinterface

// File: rtl/div_arbiter_long_division.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// start sampled at edge S: done pulses after edge S+WIDTH, or after S+1
// when the divisor is zero (dbz set, quotient and remainder zero).
module longDivision #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic             o_dbz,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH:0]   shifted;

  // Partial remainder with the next dividend bit shifted in.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
  end

  // Load on start, then one restoring step per cycle until the count expires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= '0;
      dvs  <= '0;
      q    <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_start && !busy) begin
        busy <= 1'b1;
        dvs  <= i_b;
        q    <= i_a;
        r    <= '0;
        dbz  <= (i_b == '0);
        cnt  <= (i_b == '0) ? '0 : CW'(WIDTH);
      end else if (busy) begin
        if (cnt == '0) begin
          // zero divisor: no iterations, clean zero results
          busy <= 1'b0;
          done <= 1'b1;
          q    <= '0;
          r    <= '0;
        end else begin
          if (shifted >= {1'b0, dvs}) begin
            r <= WIDTH'(shifted - {1'b0, dvs});
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= shifted[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

  assign o_done = done;
  assign o_dbz  = dbz;
  assign o_quot = q;
  assign o_rem  = r;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among NREQ requesters.
// One job in flight: grant in IDLE, start pulse in ISSUE, wait for done,
// then hold the response until the consumer accepts it.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  div_arbiter_if.slave  bus
);
  localparam int IDW = id_width(NREQ);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  pick_t            pick;
  logic [IDW-1:0]   win;

  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [WIDTH-1:0] rsp_quot;
  logic [WIDTH-1:0] rsp_rem;
  logic             rsp_dbz;

  logic             div_start;
  logic             div_done;
  logic             div_dbz;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  // Winner search over the live valids, starting at the priority pointer.
  always_comb begin
    pick = rr_pick(MAX_NREQ'(bus.i_req_valid), 4'(ptr), NREQ);
  end

  assign win = IDW'(pick.idx);

  assign bus.o_req_ready = (state == IDLE && !i_rst && pick.found)
                           ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

  // Arbiter FSM: accept, issue, wait for the divider, hold the response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.found) begin
            a_q    <= bus.i_req_a[win*WIDTH +: WIDTH];
            b_q    <= bus.i_req_b[win*WIDTH +: WIDTH];
            gnt_id <= win;
            ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_dbz   <= div_dbz;
            // divide-by-zero results are forced, never taken from the divider
            rsp_quot  <= div_dbz ? '0 : div_quot;
            rsp_rem   <= div_dbz ? '0 : div_rem;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_valid && bus.i_rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_start = (state == ISSUE);

  longDivision #(.WIDTH(WIDTH)) u_div (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (div_start),
    .i_a     (a_q),
    .i_b     (b_q),
    .o_done  (div_done),
    .o_dbz   (div_dbz),
    .o_quot  (div_quot),
    .o_rem   (div_rem)
  );

  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_id    = rsp_id;
  assign bus.o_rsp_quot  = rsp_quot;
  assign bus.o_rsp_rem   = rsp_rem;
  assign bus.o_rsp_dbz   = rsp_dbz;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_state     = state;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with WIDTH=8, NREQ=4: a table of
// single-requester jobs, then hand-written contention, back-pressure,
// mid-job reset and pointer-wrap sequences.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int NVEC  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  div_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic [7:0] a, input logic [7:0] b);
    bus.i_req_valid[k]             = 1'b1;
    bus.i_req_a[k*WIDTH +: WIDTH] = a;
    bus.i_req_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(input int k, input string name);
    int n;
    n = 0;
    while (bus.o_req_ready[k] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({name, "_grant"}, 32'(bus.o_req_ready), 32'(1) << k);
  endtask

  task automatic wait_rsp(input string name, output int n);
    n = 0;
    while (bus.o_rsp_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check({name, "_rsp_seen"}, 32'(bus.o_rsp_valid), 32'd1);
  endtask

  // Full single job: request, grant, latency, payload, response handshake.
  task automatic run_job(input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                         input int elat, input string name);
    int n;
    drive_req(k, a, b);
    #1;
    wait_grant(k, name);
    step();                       // accept edge T
    bus.i_req_valid[k] = 1'b0;
    check({name, "_busy"}, 32'(bus.o_busy), 32'd1);
    wait_rsp(name, n);
    check({name, "_lat"}, 32'(n), 32'(elat));
    check({name, "_id"}, 32'(bus.o_rsp_id), 32'(k));
    check({name, "_quot"}, 32'(bus.o_rsp_quot), 32'(eq));
    check({name, "_rem"}, 32'(bus.o_rsp_rem), 32'(er));
    check({name, "_dbz"}, 32'(bus.o_rsp_dbz), 32'(edbz));
    bus.i_rsp_ready = 1'b1;
    step();                       // handshake edge R
    bus.i_rsp_ready = 1'b0;
    check({name, "_rsp_clear"}, 32'(bus.o_rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          seen;
    logic [31:0] hold_val;
    logic [31:0] exp_id;
    logic [7:0]  ea;
    logic [7:0]  eb;

    vecs[0] = '{k: 2, a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2, dbz: 1'b0, lat: 10};
    vecs[1] = '{k: 1, a: 8'd5,   b: 8'd0,   q: 8'd0,   r: 8'd0, dbz: 1'b1, lat: 3};
    vecs[2] = '{k: 0, a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0, dbz: 1'b0, lat: 10};
    vecs[3] = '{k: 3, a: 8'd7,   b: 8'd9,   q: 8'd0,   r: 8'd7, dbz: 1'b0, lat: 10};
    vecs[4] = '{k: 0, a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0, dbz: 1'b0, lat: 10};
    vecs[5] = '{k: 2, a: 8'd200, b: 8'd13,  q: 8'd15,  r: 8'd5, dbz: 1'b0, lat: 10};
    vecs[6] = '{k: 1, a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0, dbz: 1'b0, lat: 10};
    vecs[7] = '{k: 3, a: 8'd255, b: 8'd0,   q: 8'd0,   r: 8'd0, dbz: 1'b1, lat: 3};

    // reset with every requester valid: no grant may leak out
    rst             = 1'b1;
    bus.i_req_valid = '1;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b0;
    step();
    step();
    check("rst_ready", 32'(bus.o_req_ready), 32'd0);
    check("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_id",    32'(bus.o_rsp_id),    32'd0);
    check("rst_quot",  32'(bus.o_rsp_quot),  32'd0);
    check("rst_rem",   32'(bus.o_rsp_rem),   32'd0);
    check("rst_dbz",   32'(bus.o_rsp_dbz),   32'd0);
    check("rst_busy",  32'(bus.o_busy),      32'd0);
    check("rst_state", 32'(bus.o_state),     32'(IDLE));
    bus.i_req_valid = '0;
    rst = 1'b0;
    step();

    // single-requester table; pointer ends at 0 after the last (k=3) entry
    for (int i = 0; i < NVEC; i++) begin
      run_job(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].dbz, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // all four contend, consumer always ready: grants 0,1,2,3,0,1
    for (int k = 0; k < NREQ; k++) drive_req(k, 8'(200 + k), 8'(k + 3));
    bus.i_rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (bus.o_req_ready === '0 && n < 50) begin
        step();
        n++;
      end
      check($sformatf("rr_grant%0d", g), 32'(bus.o_req_ready), 32'(1) << (g % NREQ));
      exp_q.push_back(32'(g % NREQ));
      step();
      check($sformatf("rr_noready%0d", g), 32'(bus.o_req_ready), 32'd0);
      wait_rsp($sformatf("rr%0d", g), n);
      exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      ea = 8'(200 + exp_id);
      eb = 8'(exp_id + 3);
      check($sformatf("rr_id%0d", g),   32'(bus.o_rsp_id),   exp_id);
      check($sformatf("rr_quot%0d", g), 32'(bus.o_rsp_quot), 32'(ea / eb));
      check($sformatf("rr_rem%0d", g),  32'(bus.o_rsp_rem),  32'(ea % eb));
      step();                     // handshake
    end
    bus.i_req_valid = '0;
    bus.i_rsp_ready = 1'b0;
    step();

    // back-pressure: pointer is 2, only requester 0 asks; 50/6 = 8 r 2
    drive_req(0, 8'd50, 8'd6);
    #1;
    wait_grant(0, "hold");
    step();
    bus.i_req_valid[0] = 1'b0;
    drive_req(2, 8'd90, 8'd9);    // waiting requester must not be granted yet
    wait_rsp("hold", n);
    check("hold_lat", 32'(n), 32'd10);
    hold_val = {8'd0, 1'b1, 2'd0, 8'd8, 8'd2, 4'd0, 1'b1};
    for (int c = 0; c < 20; c++) begin
      check($sformatf("hold_stable%0d", c),
            {8'd0, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_quot, bus.o_rsp_rem,
             bus.o_req_ready, bus.o_busy}, hold_val);
      check($sformatf("hold_state%0d", c), 32'(bus.o_state), 32'(HOLD));
      step();
    end
    bus.i_rsp_ready = 1'b1;
    step();                       // handshake edge R
    bus.i_rsp_ready = 1'b0;
    check("hold_release", 32'(bus.o_rsp_valid), 32'd0);
    check("hold_next_grant", 32'(bus.o_req_ready), 32'b0100);
    step();                       // accept edge R+1
    bus.i_req_valid[2] = 1'b0;
    wait_rsp("hold_next", n);
    check("hold_next_lat",  32'(n), 32'd10);
    check("hold_next_id",   32'(bus.o_rsp_id),   32'd2);
    check("hold_next_quot", 32'(bus.o_rsp_quot), 32'd10);
    check("hold_next_rem",  32'(bus.o_rsp_rem),  32'd0);
    bus.i_rsp_ready = 1'b1;
    step();
    bus.i_rsp_ready = 1'b0;

    // reset during WAIT: pointer is 3, requester 1 wins the scan 3,0,1
    drive_req(1, 8'd255, 8'd1);
    #1;
    wait_grant(1, "mid_rst");
    step();
    bus.i_req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("mid_rst_in_wait", 32'(bus.o_state), 32'(WAIT));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", 32'(bus.o_state),     32'(IDLE));
    check("mid_rst_busy",  32'(bus.o_busy),      32'd0);
    check("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("mid_rst_id",    32'(bus.o_rsp_id),    32'd0);
    check("mid_rst_quot",  32'(bus.o_rsp_quot),  32'd0);
    check("mid_rst_ready", 32'(bus.o_req_ready), 32'd0);
    seen = 0;
    for (int c = 0; c < WIDTH + 8; c++) begin
      if (bus.o_rsp_valid === 1'b1) seen++;
      step();
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    run_job(1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 10, "post_rst");

    // pointer back to 0 by reset; only requester 3 valid, then 0/3 contend
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_job(3, 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 10, "wrap3");
    drive_req(3, 8'd33, 8'd5);
    drive_req(0, 8'd60, 8'd7);
    #1;
    check("wrap_contend", 32'(bus.o_req_ready), 32'b0001);
    run_job(0, 8'd60, 8'd7, 8'd8, 8'd4, 1'b0, 10, "wrap0");
    run_job(3, 8'd33, 8'd5, 8'd6, 8'd3, 1'b0, 10, "wrap3b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- global time limit ----------------
  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule
